lsu_ctrl: RTL and testbench

Load/store unit directly downstream of the execute-stage ALU. Takes ALUResult as the effective address, issues one request to data memory over a req/ack handshake, and handles byte-lane steering and sign/zero extension. It stalls the pipeline while an access is in flight and returns load data for writeback.

---
 rtl/lsu_ctrl.sv | 214 +++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store unit: one memory access per instruction over a req/ack handshake,
// with byte-lane steering, load extension and a request timeout.
// Optional misalignment trap: define LSU_MISALIGN_TRAP_EN.
module lsu_ctrl #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  MemRead,
  input  logic                  MemWrite,
  input  logic [2:0]            Funct3,
  input  logic [DATA_WIDTH-1:0] Addr,
  input  logic [DATA_WIDTH-1:0] WrData,
  output logic                  stall,
  output logic                  done,
  output logic                  err,
  output logic [DATA_WIDTH-1:0] RdData,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_be,
  input  logic                  mem_ack,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  size_t                 size_q, size_d;
  logic                  uns_q, uns_d;
  logic                  is_load_q, is_load_d;
  logic [1:0]            addr_lo_q, addr_lo_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic                  mem_req_q, mem_req_d;
  logic                  mem_we_q, mem_we_d;
  logic [DATA_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_be_q, mem_be_d;

  size_t                 req_size;
  logic [3:0]            lane_be;
  logic [DATA_WIDTH-1:0] lane_wdata;
  logic                  misaligned;
  logic [7:0]            ld_byte;
  logic [15:0]           ld_half;
  logic [DATA_WIDTH-1:0] ld_data;

  // Reserved size codes fall through to word
  always_comb begin
    case (Funct3[1:0])
      2'b00:   req_size = SZ_B;
      2'b01:   req_size = SZ_H;
      default: req_size = SZ_W;
    endcase
  end

  // Store lane steering; loads enable all lanes and carry no data
  always_comb begin
    lane_be    = 4'b1111;
    lane_wdata = '0;
    if (MemWrite) begin
      case (req_size)
        SZ_B: begin
          lane_be    = 4'b0001 << Addr[1:0];
          lane_wdata = {4{WrData[7:0]}};
        end
        SZ_H: begin
          lane_be    = Addr[1] ? 4'b1100 : 4'b0011;
          lane_wdata = {2{WrData[15:0]}};
        end
        default: lane_wdata = WrData;
      endcase
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign misaligned = ((req_size == SZ_H) && Addr[0]) ||
                      ((req_size == SZ_W) && (Addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  // Load extraction from the lane selected by the registered low address bits
  always_comb begin
    case (addr_lo_q)
      2'd0:    ld_byte = mem_rdata[7:0];
      2'd1:    ld_byte = mem_rdata[15:8];
      2'd2:    ld_byte = mem_rdata[23:16];
      default: ld_byte = mem_rdata[31:24];
    endcase
    ld_half = addr_lo_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      SZ_B:    ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    size_d      = size_q;
    uns_d       = uns_q;
    is_load_d   = is_load_q;
    addr_lo_d   = addr_lo_q;
    done_d      = 1'b0;
    err_d       = 1'b0;
    rd_data_d   = rd_data_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    stall       = 1'b0;
    case (state_q)
      IDLE: begin
        if (start && (MemRead || MemWrite)) begin
          stall     = 1'b1;
          is_load_d = ~MemWrite;
          size_d    = req_size;
          uns_d     = Funct3[2];
          addr_lo_d = Addr[1:0];
          if (misaligned) begin
            state_d = RESP;
            done_d  = 1'b1;
            err_d   = 1'b1;
          end else begin
            state_d     = REQ;
            cnt_d       = '0;
            mem_req_d   = 1'b1;
            mem_we_d    = MemWrite;
            mem_addr_d  = {Addr[DATA_WIDTH-1:2], 2'b00};
            mem_wdata_d = lane_wdata;
            mem_be_d    = lane_be;
          end
        end
      end
      REQ: begin
        stall = 1'b1;
        if (mem_ack) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
          if (is_load_q) rd_data_d = ld_data;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = RESP;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          done_d    = 1'b1;
          err_d     = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      size_q      <= SZ_W;
      uns_q       <= 1'b0;
      is_load_q   <= 1'b0;
      addr_lo_q   <= 2'b00;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      rd_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      is_load_q   <= is_load_d;
      addr_lo_q   <= addr_lo_d;
      done_q      <= done_d;
      err_q       <= err_d;
      rd_data_q   <= rd_data_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
    end
  end

  assign done      = done_q;
  assign err       = err_q;
  assign RdData    = rd_data_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign mem_be    = mem_be_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Bench for lsu_ctrl: directed vector table, reset/no-op sequences, and
// random accesses checked against a byte-level memory model.
module tb_lsu_ctrl;

  localparam int unsigned TO = 16;
`ifdef LSU_MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start, MemRead, MemWrite;
  logic [2:0]  Funct3;
  logic [31:0] Addr, WrData;
  logic        stall, done, err;
  logic [31:0] RdData;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .MemRead(MemRead), .MemWrite(MemWrite),
    .Funct3(Funct3), .Addr(Addr), .WrData(WrData), .stall(stall), .done(done), .err(err),
    .RdData(RdData), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [2:0]  f3;
    logic [31:0] addr, wdata;
    int          lat;       // req cycles until ack; 0 = never ack
    logic [31:0] rdata;
    logic [31:0] exp_addr;
    logic [3:0]  exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_done;  // cycle of the done pulse, start = cycle 0
  } vec_t;

  function automatic vec_t mk(input string n, input logic rd, input logic wr,
                              input logic [2:0] f3, input logic [31:0] a, input logic [31:0] wd,
                              input int lat, input logic [31:0] rdata, input logic [31:0] ea,
                              input logic [3:0] be, input logic [31:0] ew, input logic [31:0] er,
                              input logic e, input int dn);
    vec_t v;
    v.name = n; v.rd = rd; v.wr = wr; v.f3 = f3; v.addr = a; v.wdata = wd; v.lat = lat;
    v.rdata = rdata; v.exp_addr = ea; v.exp_be = be; v.exp_wdata = ew; v.exp_rd = er;
    v.exp_err = e; v.exp_done = dn;
    return v;
  endfunction

  // One access from cycle 0 through the cycle after done, acting as the memory
  task automatic access(input vec_t v);
    int reqs, stalls;
    bit seen;
    start = 1'b1; MemRead = v.rd; MemWrite = v.wr; Funct3 = v.f3;
    Addr = v.addr; WrData = v.wdata;
    #1;
    chk({v.name, " stall@0"}, 32'(stall), 32'd1);
    stalls = stall ? 1 : 0;
    reqs = 0;
    seen = 1'b0;
    @(posedge clk); #1;
    for (int c = 1; c <= 40 && !seen; c++) begin
      if (mem_req) begin
        reqs++;
        chk({v.name, " mem_addr"}, mem_addr, v.exp_addr);
        chk({v.name, " mem_be"}, 32'(mem_be), 32'(v.exp_be));
        chk({v.name, " mem_we"}, 32'(mem_we), 32'(v.wr));
        if (v.wr) chk({v.name, " mem_wdata"}, mem_wdata, v.exp_wdata);
        if (reqs == v.lat) begin
          mem_ack = 1'b1;
          mem_rdata = v.rdata;
        end
        start = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
        Funct3 = 3'($urandom); Addr = $urandom; WrData = $urandom;
      end else begin
        start = 1'b0;
      end
      if (done) begin
        seen = 1'b1;
        chk({v.name, " done cycle"}, 32'(c), 32'(v.exp_done));
        chk({v.name, " err"}, 32'(err), 32'(v.exp_err));
        chk({v.name, " RdData"}, RdData, v.exp_rd);
        chk({v.name, " req off at done"}, 32'(mem_req), 32'd0);
      end
      #1;
      if (stall) stalls++;
      @(posedge clk); #1;
      mem_ack = 1'b0;
      mem_rdata = $urandom;
    end
    start = 1'b0;
    chk({v.name, " done seen"}, 32'(seen), 32'd1);
    chk({v.name, " stall cycles"}, 32'(stalls), 32'(v.exp_done));
    chk({v.name, " req cycles"}, 32'(reqs), 32'(v.exp_done - 1));
    chk({v.name, " done one cycle"}, 32'(done), 32'd0);
  endtask

  // Reference model: byte-addressed words, sizes and extension from Funct3
  logic [31:0] mem [16];
  logic [31:0] rd_model;

  function automatic int size_of(input logic [2:0] f3);
    if (f3[1:0] == 2'b00) return 1;
    if (f3[1:0] == 2'b01) return 2;
    return 4;
  endfunction

  function automatic int off_of(input logic [31:0] a, input int sz);
    if (sz == 1) return int'(a % 4);
    if (sz == 2) return int'(a[1]) * 2;
    return 0;
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [2:0] f3,
                                           input int off, input int sz);
    logic [31:0] v, mask;
    if (sz == 4) return word;
    mask = (32'd1 << (8 * sz)) - 32'd1;
    v = (word >> (8 * off)) & mask;
    if (!f3[2] && v[8 * sz - 1]) v = v | ~mask;
    return v;
  endfunction

  task automatic random_access();
    vec_t v;
    int op, sz, off, r, w;
    bit misal, tmo;
    op = $urandom_range(0, 2);
    v.name = "rand";
    v.rd = (op != 1);
    v.wr = (op != 0);
    v.f3 = 3'($urandom);
    v.addr = 32'($urandom_range(0, 63));
    v.wdata = $urandom;
    r = $urandom_range(0, 15);
    v.lat = (r == 0) ? 0 : (r == 1) ? $urandom_range(17, 20) : (r == 2) ? 16 : $urandom_range(1, 5);
    sz = size_of(v.f3);
    off = off_of(v.addr, sz);
    w = int'(v.addr / 4);
    misal = TRAP && (((sz == 2) && v.addr[0]) || ((sz == 4) && (v.addr % 4 != 0)));
    tmo = (v.lat == 0) || (v.lat > TO);
    v.rdata = mem[w];
    v.exp_addr = v.addr & ~32'd3;
    for (int i = 0; i < 4; i++) begin
      v.exp_be[i] = !v.wr || ((i >= off) && (i < off + sz));
      v.exp_wdata[8 * i +: 8] = v.wdata[8 * (i % sz) +: 8];
    end
    v.exp_err = misal || tmo;
    v.exp_done = misal ? 1 : tmo ? TO + 1 : v.lat + 1;
    if (!v.exp_err) begin
      if (v.wr) begin
        for (int i = 0; i < sz; i++) mem[w][8 * (off + i) +: 8] = v.wdata[8 * i +: 8];
      end else begin
        rd_model = load_val(mem[w], v.f3, off, sz);
      end
    end
    v.exp_rd = rd_model;
    access(v);
  endtask

  vec_t tbl[$];
  logic [31:0] rd11;

  initial begin
    rst_n = 1'b0; start = 1'b0; MemRead = 1'b0; MemWrite = 1'b0; Funct3 = 3'b0;
    Addr = '0; WrData = '0; mem_ack = 1'b0; mem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset stall", 32'(stall), 32'd0);
    chk("reset done", 32'(done), 32'd0);
    chk("reset err", 32'(err), 32'd0);
    chk("reset RdData", RdData, 32'd0);
    chk("reset mem_req", 32'(mem_req), 32'd0);
    chk("reset mem_we", 32'(mem_we), 32'd0);
    chk("reset mem_addr", mem_addr, 32'd0);
    chk("reset mem_wdata", mem_wdata, 32'd0);
    chk("reset mem_be", 32'(mem_be), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    rd11 = TRAP ? 32'h0000_8001 : 32'hCAFE_F00D;
    tbl.push_back(mk("sw", 0, 1, 3'b010, 32'h100, 32'hDEADBEEF, 1, 0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0, 0, 2));
    tbl.push_back(mk("lw", 1, 0, 3'b010, 32'h100, 0, 1, 32'hDEADBEEF, 32'h100, 4'hF, 0, 32'hDEADBEEF, 0, 2));
    tbl.push_back(mk("sb", 0, 1, 3'b000, 32'h103, 32'h80, 2, 0, 32'h100, 4'h8, 32'h80808080, 32'hDEADBEEF, 0, 3));
    tbl.push_back(mk("lb", 1, 0, 3'b000, 32'h103, 0, 1, 32'h80000000, 32'h100, 4'hF, 0, 32'hFFFFFF80, 0, 2));
    tbl.push_back(mk("lbu", 1, 0, 3'b100, 32'h103, 0, 3, 32'h80000000, 32'h100, 4'hF, 0, 32'h00000080, 0, 4));
    tbl.push_back(mk("sh", 0, 1, 3'b001, 32'h202, 32'h1234, 1, 0, 32'h200, 4'hC, 32'h12341234, 32'h00000080, 0, 2));
    tbl.push_back(mk("lh", 1, 0, 3'b001, 32'h202, 0, 1, 32'h80015A5A, 32'h200, 4'hF, 0, 32'hFFFF8001, 0, 2));
    tbl.push_back(mk("lhu", 1, 0, 3'b101, 32'h202, 0, 2, 32'h80015A5A, 32'h200, 4'hF, 0, 32'h00008001, 0, 3));
    tbl.push_back(mk("sw_wait5", 0, 1, 3'b010, 32'h204, 32'h01234567, 5, 0, 32'h204, 4'hF, 32'h01234567, 32'h00008001, 0, 6));
    tbl.push_back(mk("lw_timeout", 1, 0, 3'b010, 32'h208, 0, 0, 0, 32'h208, 4'hF, 0, 32'h00008001, 1, TO + 1));
    tbl.push_back(mk("lw_misal", 1, 0, 3'b010, 32'h101, 0, 1, 32'hCAFEF00D, 32'h100, 4'hF, 0, rd11, TRAP, TRAP ? 1 : 2));
    tbl.push_back(mk("rw_both", 1, 1, 3'b000, 32'h301, 32'hAA, 1, 32'h11111111, 32'h300, 4'h2, 32'hAAAAAAAA, rd11, 0, 2));
    tbl.push_back(mk("lw_rsvd011", 1, 0, 3'b011, 32'h30C, 0, 1, 32'h13572468, 32'h30C, 4'hF, 0, 32'h13572468, 0, 2));
    tbl.push_back(mk("lw_rsvd110", 1, 0, 3'b110, 32'h30C, 0, 2, 32'h89ABCDEF, 32'h30C, 4'hF, 0, 32'h89ABCDEF, 0, 3));
    foreach (tbl[i]) access(tbl[i]);

    // Neither read nor write: no stall, no request, no done
    start = 1'b1; MemRead = 1'b0; MemWrite = 1'b0; Addr = 32'h40;
    #1;
    chk("noop stall", 32'(stall), 32'd0);
    @(posedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("noop done", 32'(done), 32'd0);
      chk("noop mem_req", 32'(mem_req), 32'd0);
      @(posedge clk); #1;
    end

    rd_model = 32'h89ABCDEF;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    for (int n = 0; n < 250; n++) random_access();

    // Reset in the middle of an outstanding load
    start = 1'b1; MemRead = 1'b1; MemWrite = 1'b0; Funct3 = 3'b010; Addr = 32'h40;
    @(posedge clk); #1;
    start = 1'b0;
    chk("midrst req up", 32'(mem_req), 32'd1);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("midrst mem_req", 32'(mem_req), 32'd0);
    chk("midrst stall", 32'(stall), 32'd0);
    chk("midrst RdData", RdData, 32'd0);
    chk("midrst done", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      chk("postrst done", 32'(done), 32'd0);
      chk("postrst mem_req", 32'(mem_req), 32'd0);
    end
    access(mk("sw_after_rst", 0, 1, 3'b010, 32'h10, 32'h55AA55AA, 2, 0, 32'h10, 4'hF, 32'h55AA55AA, 32'h0, 0, 3));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
